reaction_cue_ctrl: RTL and testbench

Game controller for the two-player reaction-time tester. It sits directly upstream of the dual RGB LED driver, and supplies that driver's `color1/color2` and `bright1/bright2`. On start it waits a pseudo-random delay, shows the "go" cue, measures the first button press in milliseconds, and reports the winner or a foul. All outputs are registered.

---
 rtl/reaction_cue_ctrl_pkg.sv | 66 ++++++
 rtl/reaction_cue_ctrl_if.sv | 30 +++
 rtl/reaction_cue_ctrl_lfsr16.sv | 27 ++
 rtl/reaction_cue_ctrl.sv | 144 ++++++++++++++
 tb/tb_reaction_cue_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reaction_cue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// reaction_pkg
// Shared state, colour and winner encodings for the reaction-time game.
// Rev 1.0
// ============================================================================
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    GO      = 3'd2,
    RESULT  = 3'd3,
    FOUL    = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  // Colour bit order is {R,G,B}
  localparam logic [2:0] C_OFF     = 3'b000;
  localparam logic [2:0] C_RED     = 3'b100;
  localparam logic [2:0] C_GREEN   = 3'b010;
  localparam logic [2:0] C_BLUE    = 3'b001;
  localparam logic [2:0] C_YELLOW  = 3'b110;
  localparam logic [2:0] C_MAGENTA = 3'b101;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;
  localparam logic [1:0] W_TIE  = 2'b11;

  localparam int MS_W = 14;

  typedef struct packed {
    logic [2:0] color1;
    logic       bright1;
    logic [2:0] color2;
    logic       bright2;
  } led_t;

  // In FOUL the winner code names the player who did NOT foul.
  function automatic led_t led_for(state_t s, logic [1:0] w);
    led_t l;
    l = '{color1: C_BLUE, bright1: 1'b0, color2: C_BLUE, bright2: 1'b0};
    case (s)
      ARMED:   l = '{C_RED, 1'b0, C_RED, 1'b0};
      GO:      l = '{C_GREEN, 1'b1, C_GREEN, 1'b1};
      RESULT: begin
        if (w == W_TIE) l = '{C_YELLOW, 1'b1, C_YELLOW, 1'b1};
        else            l = '{(w[0] ? C_GREEN : C_OFF), 1'b1,
                              (w[1] ? C_GREEN : C_OFF), 1'b1};
      end
      FOUL: begin
        case (w)
          W_P2:    l = '{C_RED, 1'b1, C_GREEN, 1'b0};
          W_P1:    l = '{C_GREEN, 1'b0, C_RED, 1'b1};
          default: l = '{C_RED, 1'b1, C_RED, 1'b1};
        endcase
      end
      TIMEOUT: l = '{C_MAGENTA, 1'b0, C_MAGENTA, 1'b0};
      default: l = '{C_BLUE, 1'b0, C_BLUE, 1'b0};
    endcase
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_cue_ctrl_if.sv
`default_nettype none
// ============================================================================
// reaction_cue_ctrl_if
// Game-control inputs and LED/result outputs of the reaction controller.
// Rev 1.0
// ============================================================================
interface reaction_cue_ctrl_if;
  logic        start;
  logic        btn1;
  logic        btn2;
  logic [2:0]  color1;
  logic [2:0]  color2;
  logic        bright1;
  logic        bright2;
  logic [1:0]  winner;
  logic        foul;
  logic [13:0] reaction_ms;
  logic        result_valid;

  modport master (
    output start, btn1, btn2,
    input  color1, color2, bright1, bright2, winner, foul, reaction_ms, result_valid
  );

  modport slave (
    input  start, btn1, btn2,
    output color1, color2, bright1, bright2, winner, foul, reaction_ms, result_valid
  );
endinterface
`default_nettype wire

// File: rtl/reaction_cue_ctrl_lfsr16.sv
`default_nettype none
// ============================================================================
// lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1.
// Rev 1.0
// ============================================================================
module lfsr16 (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Maximal-length taps: a non-zero seed can never reach the all-zero state.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/reaction_cue_ctrl.sv
`default_nettype none
// ============================================================================
// reaction_cue_ctrl
// Two-player reaction tester: random cue delay, ms timing, winner/foul report.
// Rev 1.0
// ============================================================================
module reaction_cue_ctrl
  import reaction_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic clk,
  input  logic rstn,
  reaction_cue_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [15:0]     lfsr_val;
  logic            lfsr_unused;
  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic [MS_W-1:0] delay_q, delay_d;
  logic [1:0]      winner_q, winner_d;
  logic            foul_q, foul_d;
  logic [MS_W-1:0] react_q, react_d;
  logic            valid_q, valid_d;
  led_t            led_q, led_d;

  logic            tick;
  logic            press;
  logic            clr_time;
  logic [MS_W-1:0] ms_inc;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .q    (lfsr_val)
  );

  assign lfsr_unused = ^lfsr_val;

  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign press  = bus.btn1 | bus.btn2;
  assign ms_inc = (ms_q == {MS_W{1'b1}}) ? ms_q : ms_q + MS_W'(1);

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    winner_d = winner_q;
    foul_d   = foul_q;
    react_d  = react_q;
    valid_d  = 1'b0;
    clr_time = 1'b0;

    case (state_q)
      ARMED: begin
        // Early presses beat a same-cycle cue transition.
        if (press) begin
          state_d  = FOUL;
          winner_d = {bus.btn1 & ~bus.btn2, bus.btn2 & ~bus.btn1};
          foul_d   = 1'b1;
          react_d  = '0;
          valid_d  = 1'b1;
        end else if (tick && (ms_inc >= delay_q)) begin
          state_d  = GO;
          clr_time = 1'b1;
        end
      end
      GO: begin
        if (press) begin
          state_d  = RESULT;
          winner_d = {bus.btn2, bus.btn1};
          react_d  = ms_q;
          valid_d  = 1'b1;
        end else if (tick && (ms_inc >= MS_W'(TIMEOUT_MS))) begin
          state_d  = TIMEOUT;
          winner_d = W_NONE;
          react_d  = MS_W'(TIMEOUT_MS);
          valid_d  = 1'b1;
        end
      end
      default: begin
        if (bus.start) begin
          state_d  = ARMED;
          delay_d  = MS_W'(MIN_DELAY_MS) + MS_W'(lfsr_val[RAND_BITS-1:0]);
          winner_d = W_NONE;
          foul_d   = 1'b0;
          react_d  = '0;
          clr_time = 1'b1;
        end
      end
    endcase

    if (clr_time) begin
      presc_d = '0;
      ms_d    = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      ms_d    = tick ? ms_inc : ms_q;
    end

    led_d = led_for(state_d, winner_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      ms_q     <= '0;
      delay_q  <= MS_W'(MIN_DELAY_MS);
      winner_q <= W_NONE;
      foul_q   <= 1'b0;
      react_q  <= '0;
      valid_q  <= 1'b0;
      led_q    <= '{C_BLUE, 1'b0, C_BLUE, 1'b0};
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      delay_q  <= delay_d;
      winner_q <= winner_d;
      foul_q   <= foul_d;
      react_q  <= react_d;
      valid_q  <= valid_d;
      led_q    <= led_d;
    end
  end

  assign bus.color1       = led_q.color1;
  assign bus.bright1      = led_q.bright1;
  assign bus.color2       = led_q.color2;
  assign bus.bright2      = led_q.bright2;
  assign bus.winner       = winner_q;
  assign bus.foul         = foul_q;
  assign bus.reaction_ms  = react_q;
  assign bus.result_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_cue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_reaction_cue_ctrl
// Randomised rounds against an event-time model of the reaction game.
// Rev 1.0
// ============================================================================
module tb_reaction_cue_ctrl;

  localparam int TICK = 4;
  localparam int MIND = 2;
  localparam int RBIT = 2;
  localparam int TO   = 20;

  logic clk = 1'b0;
  logic rstn;

  reaction_cue_ctrl_if bus ();

  reaction_cue_ctrl #(
    .TICK_DIV     (TICK),
    .MIN_DELAY_MS (MIND),
    .RAND_BITS    (RBIT),
    .TIMEOUT_MS   (TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: phases 0 idle,1 armed,2 go,3 result,4 foul,5 timeout; times in edges
  logic [15:0] m_lf = 16'hACE1;
  int          m_e = 0;
  int          m_g = 0;
  int          m_ph = 0;
  logic [1:0]  m_win = 2'b00;
  logic        m_foul = 1'b0, m_f1 = 1'b0, m_f2 = 1'b0, m_valid = 1'b0;
  int          m_ms = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_lf = 16'hACE1; m_e = 0; m_ph = 0; m_win = 2'b00;
      m_foul = 1'b0; m_f1 = 1'b0; m_f2 = 1'b0; m_ms = 0; m_valid = 1'b0;
    end else begin
      logic [15:0] cur;
      logic p1, p2;
      cur  = m_lf;
      m_lf = {m_lf[14:0], ^(m_lf & 16'hB400)};
      m_e++;
      m_valid = 1'b0;
      p1 = bus.btn1;
      p2 = bus.btn2;
      case (m_ph)
        1: begin
          if (p1 || p2) begin
            m_ph = 4; m_f1 = p1; m_f2 = p2; m_foul = 1'b1; m_ms = 0; m_valid = 1'b1;
            m_win = (p1 && p2) ? 2'b00 : (p1 ? 2'b10 : 2'b01);
          end else if (m_e == m_g) m_ph = 2;
        end
        2: begin
          if (p1 || p2) begin
            m_ph = 3; m_win = {p2, p1}; m_ms = (m_e - 1 - m_g) / TICK; m_valid = 1'b1;
          end else if (m_e == m_g + TO * TICK) begin
            m_ph = 5; m_win = 2'b00; m_ms = TO; m_valid = 1'b1;
          end
        end
        default: begin
          if (bus.start) begin
            m_ph = 1; m_g = m_e + (MIND + int'(cur[RBIT-1:0])) * TICK;
            m_win = 2'b00; m_foul = 1'b0; m_ms = 0;
          end
        end
      endcase
    end
  end

  // {colour,bright} per LED from the displayed phase
  function automatic logic [7:0] led_exp(int ph, logic f1, logic f2, logic [1:0] w);
    logic [3:0] l1, l2;
    case (ph)
      1: begin l1 = 4'b1000; l2 = 4'b1000; end
      2: begin l1 = 4'b0101; l2 = 4'b0101; end
      3: begin
        if (w == 2'b11) begin l1 = 4'b1101; l2 = 4'b1101; end
        else begin l1 = w[0] ? 4'b0101 : 4'b0001; l2 = w[1] ? 4'b0101 : 4'b0001; end
      end
      4: begin l1 = f1 ? 4'b1001 : 4'b0100; l2 = f2 ? 4'b1001 : 4'b0100; end
      5: begin l1 = 4'b1010; l2 = 4'b1010; end
      default: begin l1 = 4'b0010; l2 = 4'b0010; end
    endcase
    return {l1, l2};
  endfunction

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      logic [25:0] got, exp;
      got = {bus.color1, bus.bright1, bus.color2, bus.bright2, bus.winner,
             bus.foul, bus.reaction_ms, bus.result_valid};
      exp = {led_exp(m_ph, m_f1, m_f2, m_win), m_win, m_foul, 14'(m_ms), m_valid};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL model edge%0d outputs got led=%b win=%b foul=%b ms=%0d v=%b, exp led=%b win=%b foul=%b ms=%0d v=%b",
                 m_e, got[25:18], got[17:16], got[15], got[14:1], got[0],
                 exp[25:18], exp[17:16], exp[15], exp[14:1], exp[0]);
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Drive inputs so they are sampled at model edge x (must be called at a negedge)
  task automatic drive_at(int x, logic s, logic [1:0] b);
    int guard = 0;
    while (m_e < x - 1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    bus.start = s; bus.btn1 = b[0]; bus.btn2 = b[1];
    @(negedge clk);
    bus.start = 1'b0; bus.btn1 = 1'b0; bus.btn2 = 1'b0;
  endtask

  task automatic start_round();
    drive_at(m_e + 1, 1'b1, 2'b00);
  endtask

  task automatic wait_go();
    int guard = 0;
    while (m_e < m_g && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin n_vec++; n_err++; $display("FAIL wait_go bound expired"); end
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!(m_ph inside {3, 4, 5}) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (guard >= 300) begin n_err++; $display("FAIL wait_done bound expired, phase %0d", m_ph); end
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0; bus.btn1 = 1'b0; bus.btn2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_led", {bus.color1, bus.bright1, bus.color2, bus.bright2}, 8'b0010_0010);
    chk("reset_res", {bus.winner, bus.foul, bus.reaction_ms, bus.result_valid}, 0);
    rstn = 1'b1;

    // First start samples LFSR seed ACE1 -> delay 2+1 = 3 ms = 12 cycles
    start_round();
    chk("armed_led", {bus.color1, bus.bright1, bus.color2, bus.bright2}, 8'b1000_1000);
    repeat (11) @(negedge clk);
    chk("armed_hold", bus.color1, 3'b100);
    @(negedge clk);
    chk("go_led", {bus.color1, bus.bright1, bus.color2, bus.bright2}, 8'b0101_0101);
    drive_at(42, 1'b0, 2'b10);
    chk("p2_win", bus.winner, 2'b10);
    chk("p2_ms", bus.reaction_ms, 7);
    chk("p2_valid", bus.result_valid, 1);
    chk("p2_led", {bus.color1, bus.bright1, bus.color2, bus.bright2}, 8'b0001_0101);
    @(negedge clk);
    chk("valid_pulse", bus.result_valid, 0);

    start_round();
    drive_at(m_e + 3, 1'b0, 2'b01);
    chk("foul1", {bus.winner, bus.foul}, 3'b101);
    chk("foul1_led", {bus.color1, bus.bright1, bus.color2, bus.bright2}, 8'b1001_0100);

    start_round();
    drive_at(m_e + 2, 1'b0, 2'b11);
    chk("foul_both", {bus.winner, bus.foul, bus.color1, bus.bright1, bus.color2, bus.bright2},
        {2'b00, 1'b1, 8'b1001_1001});

    start_round();
    wait_go();
    drive_at(m_g + 5, 1'b0, 2'b11);
    chk("tie", {bus.winner, bus.color1, bus.bright1, bus.color2, bus.bright2},
        {2'b11, 8'b1101_1101});

    start_round();
    wait_go();
    chk("to_go", bus.color1, 3'b010);
    repeat (79) @(negedge clk);
    chk("to_hold", bus.color1, 3'b010);
    @(negedge clk);
    chk("to_ms", bus.reaction_ms, TO);
    chk("to_led", {bus.color1, bus.bright1, bus.color2, bus.bright2, bus.result_valid},
        {8'b1010_1010, 1'b1});
    start_round();
    chk("rearm_clear", {bus.winner, bus.foul, bus.reaction_ms}, 0);

    // Asynchronous reset in the middle of ARMED
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk("async_rst", {bus.color1, bus.bright1, bus.color2, bus.bright2, bus.result_valid},
           {8'b0010_0010, 1'b0});
    @(negedge clk);
    chk("rst_novalid", bus.result_valid, 0);
    rstn = 1'b1;

    start_round();
    wait_go();
    drive_at(m_g + 1, 1'b1, 2'b00);
    chk("start_in_go", {bus.color1, bus.result_valid}, {3'b010, 1'b0});
    drive_at(m_g + 10, 1'b0, 2'b01);
    wait_done();

    for (int r = 0; r < 40; r++) begin
      int kind;
      logic [1:0] b;
      kind = int'($urandom_range(0, 5));
      b = 2'($urandom_range(1, 3));
      start_round();
      case (kind)
        0: drive_at(m_e + 1 + int'($urandom_range(0, m_g - m_e - 1)), 1'b0, b);
        1: drive_at(m_g, 1'b0, b);
        2: begin
          drive_at(m_g + 1, 1'b1, 2'b00);
          drive_at(m_g + 2 + int'($urandom_range(0, TO * TICK - 2)), 1'b0, b);
        end
        3: drive_at(m_g + TO * TICK, 1'b0, b);
        4: drive_at(m_g + TO * TICK + 1, 1'b0, 2'b00);
        default: begin
          drive_at(m_g + TO * TICK + 1, 1'b0, b);
          drive_at(m_e + 2, 1'b0, b);
        end
      endcase
      wait_done();
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
